// File: rtl/fpu_cmp_arb.sv
// Round-robin arbiter and sequencer for the shared FPU compare unit.
// Two requesters, one outstanding op, registered handshake outputs.
module fpu_cmp_arb #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         req0,
  input  logic         req1,
  input  logic [1:0]   op0,
  input  logic [1:0]   op1,
  input  logic [W-1:0] a0,
  input  logic [W-1:0] b0,
  input  logic [W-1:0] a1,
  input  logic [W-1:0] b1,
  output logic         gnt0,
  output logic         gnt1,
  output logic         rsp_valid0,
  output logic         rsp_valid1,
  input  logic         rsp_ready0,
  input  logic         rsp_ready1,
  output logic         rsp_res,
  output logic         cmp_en,
  output logic [1:0]   cmp_op,
  output logic [W-1:0] cmp_a,
  output logic [W-1:0] cmp_b,
  input  logic [W-1:0] cmp_c,
  input  logic         cmp_ready,
  output logic         busy,
  output logic         err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t       state_q, state_d;
  logic         id_q, id_d;
  logic         last_q, last_d;
  logic [1:0]   gnt_q, gnt_d;
  logic [1:0]   vld_q, vld_d;
  logic         en_q, en_d;
  logic         busy_q;
  logic         err_q, err_d;
  logic         res_q, res_d;
  logic         lat;
  logic [1:0]   op_q;
  logic [W-1:0] a_q, b_q;
  logic         win;
  logic [1:0]   win_op;
  logic         acc;
  logic         unused_c;

  assign unused_c = ^cmp_c[W-1:1];

  always_comb begin
    win     = (req0 & req1) ? ~last_q : ~req0;
    win_op  = win ? op1 : op0;
    acc     = id_q ? rsp_ready1 : rsp_ready0;
    state_d = state_q;
    id_d    = id_q;
    last_d  = last_q;
    gnt_d   = 2'b00;
    vld_d   = vld_q;
    en_d    = 1'b0;
    err_d   = err_q;
    res_d   = res_q;
    lat     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (cmp_ready) err_d = 1'b1;
        if (req0 | req1) begin
          id_d   = win;
          last_d = win;
          gnt_d  = win ? 2'b10 : 2'b01;
          if (win_op == 2'b11) begin
            // reserved op: answer 0 directly, unit untouched
            state_d = RESP;
            vld_d   = gnt_d;
            res_d   = 1'b0;
            err_d   = 1'b1;
          end else begin
            state_d = ISSUE;
            en_d    = 1'b1;
            lat     = 1'b1;
          end
        end
      end
      ISSUE: state_d = WAIT;
      WAIT: begin
        if (cmp_ready) begin
          state_d = RESP;
          vld_d   = id_q ? 2'b10 : 2'b01;
          res_d   = cmp_c[0];
        end
      end
      RESP: begin
        if (cmp_ready) err_d = 1'b1;
        if (acc) begin
          state_d = IDLE;
          vld_d   = 2'b00;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      id_q    <= 1'b0;
      last_q  <= 1'b1;
      gnt_q   <= 2'b00;
      vld_q   <= 2'b00;
      en_q    <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
      res_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      id_q    <= id_d;
      last_q  <= last_d;
      gnt_q   <= gnt_d;
      vld_q   <= vld_d;
      en_q    <= en_d;
      busy_q  <= (state_d != IDLE);
      err_q   <= err_d;
      res_q   <= res_d;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      op_q <= 2'b00;
      a_q  <= '0;
      b_q  <= '0;
    end else if (lat) begin
      op_q <= win_op;
      a_q  <= win ? a1 : a0;
      b_q  <= win ? b1 : b0;
    end
  end

  assign gnt0       = gnt_q[0];
  assign gnt1       = gnt_q[1];
  assign rsp_valid0 = vld_q[0];
  assign rsp_valid1 = vld_q[1];
  assign rsp_res    = res_q;
  assign cmp_en     = en_q;
  assign cmp_op     = op_q;
  assign cmp_a      = a_q;
  assign cmp_b      = b_q;
  assign busy       = busy_q;
  assign err        = err_q;

endmodule
